fifo_write_arbiter: RTL and testbench

//   Shares the single write port of a downstream FIFO between NUM_REQ requesters.

---
 rtl/fifo_write_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// The winner keeps the port for up to MAX_BURST beats, or until it withdraws.
`timescale 1ns/1ps
module fifo_write_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wen,
    output logic [WIDTH-1:0]           fifo_din,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST) + 1;

    localparam logic StIdle  = 1'b0;
    localparam logic StGrant = 1'b1;

    logic             state_q, state_d;
    logic [IdW-1:0]   owner_q, owner_d;
    logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [IdW-1:0]   pick;
    logic [IdW-1:0]   idx;
    logic [IdW-1:0]   owner_next;
    logic             owner_valid;
    logic             burst_done;
    logic [WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
    end

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        pick = rr_ptr_q;
        idx  = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            idx = IdW'((32'(rr_ptr_q) + 32'(i)) % NUM_REQ);
            if (req_valid[idx]) begin
                pick = idx;
            end
        end
    end

    assign owner_valid = req_valid[owner_q];
    assign owner_next  = (owner_q == IdW'(NUM_REQ - 1)) ? '0 : owner_q + IdW'(1);

    always_comb begin
        req_ready = '0;
        fifo_wen  = 1'b0;
        fifo_din  = '0;
        if (state_q == StGrant) begin
            req_ready[owner_q] = !fifo_full;
            fifo_wen           = owner_valid & !fifo_full;
            fifo_din           = data_arr[owner_q];
        end
    end

    assign burst_done = fifo_wen && (beat_cnt_q == CntW'(MAX_BURST - 1));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    state_d    = StGrant;
                    owner_d    = pick;
                    beat_cnt_d = '0;
                end
            end
            StGrant: begin
                // A full FIFO blocks the beat but never the ownership.
                if (!owner_valid || burst_done) begin
                    state_d    = StIdle;
                    rr_ptr_d   = owner_next;
                    beat_cnt_d = '0;
                end else if (fifo_wen) begin
                    beat_cnt_d = beat_cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant_id = owner_q;
    assign busy     = (state_q == StGrant);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed vector table, hand sequences
// for corner cases, and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned WIDTH     = 64;
    localparam int unsigned MAX_BURST = 4;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_full = 1'b0;
    logic                     fifo_wen;
    logic [WIDTH-1:0]         fifo_din;
    logic [1:0]               grant_id;
    logic                     busy;

    int checks = 0;
    int failures = 0;

    fifo_write_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .WIDTH    (WIDTH),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full),
        .fifo_wen (fifo_wen),
        .fifo_din (fifo_din),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        fifo_full = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       full;
        logic       busy;
        logic [1:0] gid;
        logic       wen;
        logic [3:0] ready;
    } vec_t;

    vec_t vt [10];

    // Random-test state
    logic [3:0] vld, acc, e_ready;
    logic       e_wen;
    logic [63:0] e_din;
    int gseq [4];
    int sb_seq [4];
    int m_busy, m_owner, m_cnt, m_ptr, id, j;
    bit found;

    initial begin
        // Test 1: req0 alone for 6 beats
        vt[0] = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        vt[1] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001};
        vt[2] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001};
        vt[3] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001};
        vt[4] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001};
        vt[5] = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        vt[6] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001};
        vt[7] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001};
        vt[8] = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0001};
        vt[9] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};

        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_wen", 64'(fifo_wen), 64'd0);
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_gid", 64'(grant_id), 64'd0);
        chk("reset_din", fifo_din, 64'd0);

        do_reset();
        for (int r = 0; r < 10; r++) begin
            req_valid           = vt[r].valid;
            fifo_full           = vt[r].full;
            req_data[63:0]      = 64'hDEAD_0000 + 64'(r);
            #1;
            chk($sformatf("t1_busy[%0d]", r), 64'(busy), 64'(vt[r].busy));
            chk($sformatf("t1_gid[%0d]", r), 64'(grant_id), 64'(vt[r].gid));
            chk($sformatf("t1_wen[%0d]", r), 64'(fifo_wen), 64'(vt[r].wen));
            chk($sformatf("t1_ready[%0d]", r), 64'(req_ready), 64'(vt[r].ready));
            chk($sformatf("t1_din[%0d]", r), fifo_din,
                vt[r].busy ? 64'hDEAD_0000 + 64'(r) : 64'd0);
            tick();
        end

        // Test 2: all requesters valid -> 0,1,2,3,0 with one bubble each
        do_reset();
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk($sformatf("t2_bubble_busy[%0d]", g), 64'(busy), 64'd0);
            chk($sformatf("t2_bubble_wen[%0d]", g), 64'(fifo_wen), 64'd0);
            tick();
            for (int b = 0; b < 4; b++) begin
                #1;
                chk($sformatf("t2_gid[%0d.%0d]", g, b), 64'(grant_id), 64'(g % 4));
                chk($sformatf("t2_wen[%0d.%0d]", g, b), 64'(fifo_wen), 64'd1);
                tick();
            end
        end

        // Test 3: req1 owner stalled by full for 3 cycles after beat 2
        do_reset();
        req_valid = 4'b0010;
        #1;
        chk("t3_idle", 64'(busy), 64'd0);
        tick();
        for (int c = 0; c < 7; c++) begin
            fifo_full = (c >= 2 && c < 5);
            #1;
            chk($sformatf("t3_gid[%0d]", c), 64'(grant_id), 64'd1);
            chk($sformatf("t3_busy[%0d]", c), 64'(busy), 64'd1);
            chk($sformatf("t3_wen[%0d]", c), 64'(fifo_wen), 64'(!fifo_full));
            chk($sformatf("t3_ready[%0d]", c), 64'(req_ready), fifo_full ? 64'd0 : 64'd2);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        chk("t3_release", 64'(busy), 64'd0);
        tick();
        #1;
        chk("t3_regrant", 64'(grant_id), 64'd1);

        // Test 4: req2 withdraws after 2 beats -> next grant is 3, not 0
        do_reset();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b1101;
        #1;
        chk("t4_gid", 64'(grant_id), 64'd2);
        chk("t4_wen0", 64'(fifo_wen), 64'd1);
        tick();
        tick();
        req_valid = 4'b1001;
        #1;
        chk("t4_drop_wen", 64'(fifo_wen), 64'd0);
        tick();
        #1;
        chk("t4_release", 64'(busy), 64'd0);
        tick();
        #1;
        chk("t4_next_gid", 64'(grant_id), 64'd3);
        chk("t4_next_busy", 64'(busy), 64'd1);

        // Test 5: async reset mid-burst
        do_reset();
        req_valid = 4'b0001;
        tick();
        tick();
        #1;
        chk("t5_beat2_wen", 64'(fifo_wen), 64'd1);
        reset = 1'b0;
        #1;
        chk("t5_rst_wen", 64'(fifo_wen), 64'd0);
        chk("t5_rst_ready", 64'(req_ready), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        tick();
        reset = 1'b1;
        req_valid = 4'b1010;
        #1;
        chk("t5_idle", 64'(busy), 64'd0);
        tick();
        #1;
        chk("t5_first_gid", 64'(grant_id), 64'd1);

        // Test 6: randomized traffic against a transaction-level model
        do_reset();
        vld = '0;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            gseq[i]   = 0;
            sb_seq[i] = 0;
        end
        m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) gseq[i]++;
                if (!(vld[i] && !acc[i])) vld[i] = ($urandom_range(99) < 55);
                req_data[i*64 +: 64] = {8'(i), 56'(gseq[i])};
            end
            req_valid = vld;
            fifo_full = ($urandom_range(99) < 25);
            #1;
            e_ready = '0;
            e_wen   = 1'b0;
            e_din   = '0;
            if (m_busy != 0) begin
                e_ready[m_owner] = !fifo_full;
                e_wen            = vld[m_owner] && !fifo_full;
                e_din            = {8'(m_owner), 56'(gseq[m_owner])};
            end
            chk("rnd_busy", 64'(busy), 64'(m_busy != 0));
            if (m_busy != 0) chk("rnd_gid", 64'(grant_id), 64'(m_owner));
            chk("rnd_wen", 64'(fifo_wen), 64'(e_wen));
            chk("rnd_ready", 64'(req_ready), 64'(e_ready));
            chk("rnd_din", fifo_din, e_din);
            if (fifo_wen) begin
                chk("rnd_write_while_full", 64'(fifo_full), 64'd0);
                id = int'(fifo_din[63:56]);
                if (id < 4) begin
                    chk("rnd_seq", 64'(fifo_din[55:0]), 64'(sb_seq[id]));
                    sb_seq[id]++;
                end else begin
                    chk("rnd_id", 64'(id), 64'(grant_id));
                end
            end
            acc = vld & e_ready;
            if (m_busy == 0) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    j = (m_ptr + k) % 4;
                    if (!found && vld[j]) begin
                        found   = 1'b1;
                        m_busy  = 1;
                        m_owner = j;
                        m_cnt   = 0;
                    end
                end
            end else if (!vld[m_owner]) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % 4;
                m_cnt  = 0;
            end else if (e_wen) begin
                m_cnt++;
                if (m_cnt == MAX_BURST) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % 4;
                    m_cnt  = 0;
                end
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) gseq[i]++;
            chk($sformatf("rnd_total[%0d]", i), 64'(sb_seq[i]), 64'(gseq[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
